// File: rtl/stream_share_sched.sv
// Two-requester scheduler sharing one streaming core: arbitrates a job, feeds
// PKT_LEN words into the core, then routes RES_LEN result words back to the owner.
module stream_share_sched #(
    parameter int PKT_LEN = 16,
    parameter int RES_LEN = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s0_TVALID,
    output logic        s0_TREADY,
    input  logic [31:0] s0_TDATA,
    input  logic        s1_TVALID,
    output logic        s1_TREADY,
    input  logic [31:0] s1_TDATA,
    output logic        m0_TVALID,
    input  logic        m0_TREADY,
    output logic [31:0] m0_TDATA,
    output logic        m1_TVALID,
    input  logic        m1_TREADY,
    output logic [31:0] m1_TDATA,
    output logic        core_in_TVALID,
    input  logic        core_in_TREADY,
    output logic [31:0] core_in_TDATA,
    input  logic        core_out_TVALID,
    output logic        core_out_TREADY,
    input  logic [31:0] core_out_TDATA,
    output logic        grant,
    output logic        busy,
    output logic [15:0] done0,
    output logic [15:0] done1
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    localparam logic [15:0] FEED_LAST  = 16'(PKT_LEN - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(RES_LEN - 1);

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic [15:0] feed_cnt;
    logic [15:0] drain_cnt;
    logic [15:0] done0_q;
    logic [15:0] done1_q;
    logic        any_req;
    logic        pick;
    logic        feed_hs;
    logic        drain_hs;
    logic        feed_last;
    logic        drain_last;

    // Under contention the requester that was not served last wins.
    assign any_req    = s0_TVALID || s1_TVALID;
    assign pick       = (s0_TVALID && s1_TVALID) ? ~last_grant : s1_TVALID;
    assign feed_hs    = core_in_TVALID && core_in_TREADY;
    assign drain_hs   = core_out_TVALID && core_out_TREADY;
    assign feed_last  = feed_hs && (feed_cnt == FEED_LAST);
    assign drain_last = drain_hs && (drain_cnt == DRAIN_LAST);

    assign busy          = (state != IDLE);
    assign done0         = done0_q;
    assign done1         = done1_q;
    assign core_in_TDATA = grant ? s1_TDATA : s0_TDATA;
    assign m0_TDATA      = core_out_TDATA;
    assign m1_TDATA      = core_out_TDATA;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)    state_nxt = FEED;
            FEED:    if (feed_last)  state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_in_TVALID  = 1'b0;
        s0_TREADY       = 1'b0;
        s1_TREADY       = 1'b0;
        m0_TVALID       = 1'b0;
        m1_TVALID       = 1'b0;
        core_out_TREADY = 1'b0;
        case (state)
            FEED: begin
                core_in_TVALID = grant ? s1_TVALID : s0_TVALID;
                s0_TREADY      = !grant && core_in_TREADY;
                s1_TREADY      = grant && core_in_TREADY;
            end
            DRAIN: begin
                m0_TVALID       = !grant && core_out_TVALID;
                m1_TVALID       = grant && core_out_TVALID;
                core_out_TREADY = grant ? m1_TREADY : m0_TREADY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            feed_cnt   <= '0;
            drain_cnt  <= '0;
            done0_q    <= '0;
            done1_q    <= '0;
        end else begin
            if (state == IDLE && any_req) grant <= pick;
            if (feed_hs)  feed_cnt  <= feed_last  ? 16'd0 : feed_cnt + 16'd1;
            if (drain_hs) drain_cnt <= drain_last ? 16'd0 : drain_cnt + 16'd1;
            if (drain_last) begin
                last_grant <= grant;
                if (grant) done1_q <= done1_q + 16'd1;
                else       done0_q <= done0_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_stream_share_sched.sv
// Self-checking bench: job-level reference model of arbitration, routing and
// completion counts, with a behavioural core that returns sum+k per job.
module tb_stream_share_sched;

    localparam int PKT_LEN = 4;
    localparam int RES_LEN = 2;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s0_TVALID, s0_TREADY, s1_TVALID, s1_TREADY;
    logic [31:0] s0_TDATA, s1_TDATA;
    logic        m0_TVALID, m0_TREADY, m1_TVALID, m1_TREADY;
    logic [31:0] m0_TDATA, m1_TDATA;
    logic        core_in_TVALID, core_in_TREADY, core_out_TVALID, core_out_TREADY;
    logic [31:0] core_in_TDATA, core_out_TDATA;
    logic        grant, busy;
    logic [15:0] done0, done1;

    stream_share_sched #(.PKT_LEN(PKT_LEN), .RES_LEN(RES_LEN)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_TVALID(s0_TVALID), .s0_TREADY(s0_TREADY), .s0_TDATA(s0_TDATA),
        .s1_TVALID(s1_TVALID), .s1_TREADY(s1_TREADY), .s1_TDATA(s1_TDATA),
        .m0_TVALID(m0_TVALID), .m0_TREADY(m0_TREADY), .m0_TDATA(m0_TDATA),
        .m1_TVALID(m1_TVALID), .m1_TREADY(m1_TREADY), .m1_TDATA(m1_TDATA),
        .core_in_TVALID(core_in_TVALID), .core_in_TREADY(core_in_TREADY),
        .core_in_TDATA(core_in_TDATA),
        .core_out_TVALID(core_out_TVALID), .core_out_TREADY(core_out_TREADY),
        .core_out_TDATA(core_out_TDATA),
        .grant(grant), .busy(busy), .done0(done0), .done1(done1)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [1:0]  mask;
        logic        exp_grant;
        bit          bp;
        bit          early;
        logic [15:0] exp_done0;
        logic [15:0] exp_done1;
    } vec_t;

    vec_t        vecs[10];
    int          errors = 0;
    int          checks = 0;

    logic [31:0] src_word [2];
    logic [1:0]  src_en;
    bit          bp;
    bit          preloaded;
    logic [31:0] core_res[$];
    logic [31:0] exp_res[$];
    logic [31:0] got_res[$];
    logic [31:0] fed_sum;
    int          fed;
    int          drained;
    logic        job_g;
    logic        last_m;
    logic [15:0] done_m [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit go();
        return !bp || ($urandom_range(0, 1) == 1);
    endfunction

    // One clock: drive inputs, let logic settle, check routing, apply handshakes.
    task automatic cycle();
        logic [1:0] sv;
        logic own_sr, oth_sr, own_mv, oth_mv, own_mr;
        logic bad;
        sv[0] = src_en[0] && (!busy || go());
        sv[1] = src_en[1] && (!busy || go());
        s0_TVALID = sv[0];
        s1_TVALID = sv[1];
        s0_TDATA  = src_word[0];
        s1_TDATA  = src_word[1];
        core_in_TREADY  = go();
        core_out_TVALID = (core_res.size() != 0) && go();
        core_out_TDATA  = (core_res.size() != 0) ? core_res[0] : $urandom;
        m0_TREADY = go();
        m1_TREADY = go();
        #1;
        own_sr = job_g ? s1_TREADY : s0_TREADY;
        oth_sr = job_g ? s0_TREADY : s1_TREADY;
        own_mv = job_g ? m1_TVALID : m0_TVALID;
        oth_mv = job_g ? m0_TVALID : m1_TVALID;
        own_mr = job_g ? m1_TREADY : m0_TREADY;
        bad = 1'b0;
        if (!busy)
            bad = core_in_TVALID | s0_TREADY | s1_TREADY | core_out_TREADY | m0_TVALID | m1_TVALID;
        else if (grant !== job_g || oth_sr || oth_mv)
            bad = 1'b1;
        else if (fed < PKT_LEN)
            bad = core_out_TREADY | own_mv | (core_in_TVALID !== sv[job_g]) |
                  (own_sr !== core_in_TREADY) | (core_in_TDATA !== src_word[job_g]);
        else
            bad = core_in_TVALID | own_sr | (own_mv !== core_out_TVALID) |
                  (core_out_TREADY !== own_mr);
        if (m0_TDATA !== core_out_TDATA || m1_TDATA !== core_out_TDATA) bad = 1'b1;
        check("route_invariant", {31'd0, bad}, 32'd0);

        if (core_in_TVALID && core_in_TREADY) begin
            check("feed_data", core_in_TDATA, src_word[job_g]);
            fed_sum += core_in_TDATA;
            fed++;
            if (fed == PKT_LEN && !preloaded)
                for (int k = 0; k < RES_LEN; k++) begin
                    core_res.push_back(fed_sum + 32'(k));
                    exp_res.push_back(fed_sum + 32'(k));
                end
        end
        if (s0_TVALID && s0_TREADY) src_word[0] += 32'd1;
        if (s1_TVALID && s1_TREADY) src_word[1] += 32'd1;
        if (core_out_TVALID && core_out_TREADY && core_res.size() != 0) void'(core_res.pop_front());
        if (own_mv && own_mr) begin
            if (exp_res.size() == 0) check("drain_extra", 32'd1, 32'd0);
            else                     check("drain_data", core_out_TDATA, exp_res.pop_front());
            got_res.push_back(core_out_TDATA);
            drained++;
            if (drained == RES_LEN) begin
                done_m[job_g] += 16'd1;
                last_m = job_g;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic run_job(input logic [1:0] mask, input logic exp_g, input bit use_bp,
                           input bit early, input int abort_after);
        logic [31:0] s;
        job_g = exp_g; fed = 0; drained = 0; fed_sum = 0;
        bp = use_bp; preloaded = early; got_res.delete();
        if (early) begin
            s = 0;
            for (int k = 0; k < PKT_LEN; k++) s += src_word[exp_g] + 32'(k);
            for (int k = 0; k < RES_LEN; k++) begin
                core_res.push_back(s + 32'(k));
                exp_res.push_back(s + 32'(k));
            end
        end
        src_en = mask;
        for (int n = 0; n < 500; n++) begin
            cycle();
            if (drained == RES_LEN || (abort_after != 0 && fed == abort_after)) break;
        end
        src_en = 2'b00;
        bp = 1'b0;
        if (abort_after != 0) begin
            check("feed_progress", 32'(fed), 32'(abort_after));
        end else begin
            check("job_complete", 32'(drained), 32'(RES_LEN));
            check("idle_after_job", {31'd0, busy}, 32'd0);
            check("grant_held", {31'd0, grant}, {31'd0, exp_g});
            check("done0", {16'd0, done0}, {16'd0, done_m[0]});
            check("done1", {16'd0, done1}, {16'd0, done_m[1]});
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {31'd0, grant}, 32'd0);
        check("rst_done", {done0, done1}, 32'd0);
        check("rst_outputs", {26'd0, core_in_TVALID, s0_TREADY, s1_TREADY,
                              core_out_TREADY, m0_TVALID, m1_TVALID}, 32'd0);
        core_res.delete();
        exp_res.delete();
        last_m = 1'b1;
        done_m[0] = 16'd0;
        done_m[1] = 16'd0;
        src_en = 2'b00;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        logic [1:0] mask;
        logic       g;
        vecs[0] = '{2'b11, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
        vecs[1] = '{2'b11, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1};
        vecs[2] = '{2'b11, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1};
        vecs[3] = '{2'b11, 1'b1, 1'b0, 1'b0, 16'd2, 16'd2};
        vecs[4] = '{2'b01, 1'b0, 1'b1, 1'b0, 16'd3, 16'd2};
        vecs[5] = '{2'b10, 1'b1, 1'b1, 1'b0, 16'd3, 16'd3};
        vecs[6] = '{2'b11, 1'b0, 1'b1, 1'b0, 16'd4, 16'd3};
        vecs[7] = '{2'b01, 1'b0, 1'b0, 1'b1, 16'd5, 16'd3};
        vecs[8] = '{2'b10, 1'b1, 1'b0, 1'b1, 16'd5, 16'd4};
        vecs[9] = '{2'b11, 1'b0, 1'b1, 1'b0, 16'd6, 16'd4};

        src_word[0] = 32'h1;
        src_word[1] = 32'h100;
        src_en = 2'b00; bp = 1'b0; preloaded = 1'b0;
        fed = 0; drained = 0; fed_sum = 0; job_g = 1'b0;
        s0_TVALID = 0; s1_TVALID = 0; s0_TDATA = 0; s1_TDATA = 0;
        m0_TREADY = 0; m1_TREADY = 0; core_in_TREADY = 0;
        core_out_TVALID = 0; core_out_TDATA = 0;
        aresetn = 1'b1;
        #1;
        do_reset();

        // Single s0 job: words 1..4 sum to 0xA, so the core returns 0xA, 0xB.
        run_job(2'b01, 1'b0, 1'b0, 1'b0, 0);
        check("single_res0", got_res.size() > 0 ? got_res[0] : 32'hX, 32'hA);
        check("single_res1", got_res.size() > 1 ? got_res[1] : 32'hX, 32'hB);

        do_reset();
        foreach (vecs[i]) begin
            run_job(vecs[i].mask, vecs[i].exp_grant, vecs[i].bp, vecs[i].early, 0);
            check("tbl_done0", {16'd0, done0}, {16'd0, vecs[i].exp_done0});
            check("tbl_done1", {16'd0, done1}, {16'd0, vecs[i].exp_done1});
        end

        for (int j = 0; j < 30; j++) begin
            mask = 2'($urandom_range(1, 3));
            g = (mask == 2'b11) ? ~last_m : mask[1];
            run_job(mask, g, 1'b1, 1'($urandom_range(0, 1)), 0);
        end

        // Reset after two of four feed words: job abandoned, nothing counted.
        run_job(2'b01, 1'b0, 1'b0, 1'b0, 2);
        check("busy_midfeed", {31'd0, busy}, 32'd1);
        do_reset();
        run_job(2'b11, 1'b0, 1'b0, 1'b0, 0);
        check("post_reset_done0", {16'd0, done0}, 32'd1);

        // Preload the completion counter near its limit and let one job wrap it.
        force dut.done0_q = 16'hFFFF;
        #1;
        release dut.done0_q;
        done_m[0] = 16'hFFFF;
        run_job(2'b01, 1'b0, 1'b0, 1'b0, 0);
        check("done0_wrap", {16'd0, done0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
